// File: rtl/alu_pkg.sv
// Shared encodings and command types for the 4-bit ALU operand/result issuer.
package alu_pkg;

    localparam logic [2:0] MODE_ADD = 3'b000;
    localparam logic [2:0] MODE_SUB = 3'b001;
    localparam logic [2:0] MODE_MUL = 3'b010;
    localparam logic [2:0] MODE_DIV = 3'b011;
    localparam logic [2:0] MODE_AND = 3'b100;
    localparam logic [2:0] MODE_OR  = 3'b101;
    localparam logic [2:0] MODE_XOR = 3'b110;
    localparam logic [2:0] MODE_NOT = 3'b111;

    localparam logic [7:0] DIV0_RESULT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] mode;
        logic [3:0] a;
        logic [3:0] b;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    function automatic logic is_div0(input alu_cmd_t cmd);
        return (cmd.mode == MODE_DIV) && (cmd.b == 4'd0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: pointer-plus-count, first-word-fall-through head for the issuer FSM.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Pushes into a full FIFO and pops from an empty one are silently dropped.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues queued ALU commands one at a time, waits out the ALU latency and
// returns results in order; divide-by-zero commands are answered locally.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_mode,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [2:0] alu_mode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [7:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [2:0] res_mode,
    output logic       res_err,
    output logic       busy,
    output logic [7:0] div0_count
);

    localparam logic [2:0] LAT_CNT = 3'(ALU_LATENCY);

    alu_cmd_t         w_push_cmd;
    alu_cmd_t         w_head;
    logic [CMD_W-1:0] w_fifo_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;

    state_e     r_state;
    logic [2:0] r_wait_cnt;
    logic [2:0] r_alu_mode;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [7:0] r_res_data;
    logic [2:0] r_res_mode;
    logic       r_res_err;
    logic [7:0] r_div0_count;

    assign w_push_cmd = '{mode: cmd_mode, a: cmd_a, b: cmd_b};
    assign w_head     = alu_cmd_t'(w_fifo_data);
    assign w_pop      = (r_state == ST_IDLE) && !w_fifo_empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_alu_mode   <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_res_data   <= '0;
            r_res_mode   <= '0;
            r_res_err    <= 1'b0;
            r_div0_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        if (is_div0(w_head)) begin
                            // Never reaches the ALU; alu_* keep their last issue.
                            r_res_data <= DIV0_RESULT;
                            r_res_mode <= MODE_DIV;
                            r_res_err  <= 1'b1;
                            if (r_div0_count != 8'hFF) begin
                                r_div0_count <= r_div0_count + 8'd1;
                            end
                            r_state <= ST_HOLD;
                        end else begin
                            r_alu_mode <= w_head.mode;
                            r_alu_a    <= w_head.a;
                            r_alu_b    <= w_head.b;
                            r_wait_cnt <= '0;
                            r_state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Counter reads k-1 on edge issue+k, so capture lands on issue+LAT+1.
                    if (r_wait_cnt == LAT_CNT) begin
                        r_res_data <= alu_y;
                        r_res_mode <= r_alu_mode;
                        r_res_err  <= 1'b0;
                        r_state    <= ST_HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = !w_fifo_full;
    assign alu_mode   = r_alu_mode;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign res_valid  = (r_state == ST_HOLD);
    assign res_data   = r_res_data;
    assign res_mode   = r_res_mode;
    assign res_err    = r_res_err;
    assign busy       = (r_state != ST_IDLE) || !w_fifo_empty;
    assign div0_count = r_div0_count;

endmodule
